// File: rtl/mem_arbiter.sv
// Two-master arbiter for a shared byte-wide memory/peripheral bus.
// One transfer completes in every GRANTx cycle. Round-robin arbitration
// decides ties, and a master may hold the bus with its lock input. A hold
// counter bounds how long a lock can starve the other master.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no transfer; bus driven to zero
// GRANT0 | master 0 owns the bus; its transfer completes this cycle
// GRANT1 | master 1 owns the bus; its transfer completes this cycle
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m1_req,
    input  logic                  m0_lock,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic                  m0_we,
    input  logic                  m1_we,
    input  logic [7:0]            m0_wdata,
    input  logic [7:0]            m1_wdata,
    output logic                  m0_ack,
    output logic                  m1_ack,
    output logic [7:0]            m0_rdata,
    output logic [7:0]            m1_rdata,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [7:0]            bus_write_data,
    output logic                  bus_write_enable,
    input  logic [7:0]            bus_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // A lock may be honoured while the hold count is below this value.
    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       last_grant_q, last_grant_d;

    logic keep0;
    logic keep1;

    // A locked, still-requesting owner keeps the bus until its hold budget is spent.
    assign keep0 = m0_lock && m0_req && (hold_cnt_q < HOLD_LIMIT);
    assign keep1 = m1_lock && m1_req && (hold_cnt_q < HOLD_LIMIT);

    // State register with synchronous reset; master 1 counts as last granted so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state arbitration. The owner's req in its grant cycle belongs to the
    // transfer just completed, so only a lock lets the owner win again directly.
    always_comb begin
        state_d    = IDLE;
        hold_cnt_d = 4'd0;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (m0_req) begin
                    state_d = GRANT0;
                end else if (m1_req) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (keep0) begin
                    state_d    = GRANT0;
                    hold_cnt_d = m1_req ? hold_cnt_q + 4'd1 : 4'd0;
                end else if (m1_req) begin
                    state_d = GRANT1;
                end
            end
            GRANT1: begin
                if (keep1) begin
                    state_d    = GRANT1;
                    hold_cnt_d = m0_req ? hold_cnt_q + 4'd1 : 4'd0;
                end else if (m0_req) begin
                    state_d = GRANT0;
                end
            end
            default: state_d = IDLE;
        endcase

        last_grant_d = last_grant_q;
        if (state_d == GRANT0) begin
            last_grant_d = 1'b0;
        end else if (state_d == GRANT1) begin
            last_grant_d = 1'b1;
        end
    end

    // Bus mux and ack generation; reset kills ack and write enable within the same cycle.
    always_comb begin
        bus_address      = '0;
        bus_write_data   = 8'd0;
        bus_write_enable = 1'b0;
        m0_ack           = 1'b0;
        m1_ack           = 1'b0;
        m0_rdata         = 8'd0;
        m1_rdata         = 8'd0;
        case (state_q)
            GRANT0: begin
                bus_address      = m0_addr;
                bus_write_data   = m0_wdata;
                bus_write_enable = m0_we && !rst;
                m0_ack           = !rst;
                m0_rdata         = bus_read_data;
            end
            GRANT1: begin
                bus_address      = m1_addr;
                bus_write_data   = m1_wdata;
                bus_write_enable = m1_we && !rst;
                m1_ack           = !rst;
                m1_rdata         = bus_read_data;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of all address ports.
REQ-002 SHALL have parameter MAX_HOLD, default 4, max consecutive locked transfers one master may take while the other requests (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports m0_req/m1_req  input  1  transfer request, held until ack.
REQ-006 SHALL have ports m0_lock/m1_lock  input  1  request to keep grant for the next transfer.
REQ-007 SHALL have ports m0_addr/m1_addr  input  ADDR_WIDTH  byte address, stable while req high.
REQ-008 SHALL have ports m0_we/m1_we  input  1  write strobe of the request.
REQ-009 SHALL have ports m0_wdata/m1_wdata  input  8  write byte.
REQ-010 SHALL have ports m0_ack/m1_ack  output  1  one-cycle transfer-complete pulse.
REQ-011 SHALL have ports m0_rdata/m1_rdata  output  8  read byte, valid in ack cycle.
REQ-012 SHALL have ports bus_address  output  ADDR_WIDTH, bus_write_data  output  8, bus_write_enable  output  1: shared memory/peripheral bus.
REQ-013 SHALL have port bus_read_data  input  8  combinational read data from the shared bus.

Function
REQ-014 SHALL implement states IDLE, GRANT0, GRANT1; one transfer completes per GRANTx cycle.
REQ-015 SHALL arbitrate at every rising edge where state is IDLE or a GRANTx transfer completes: sole requester wins; both requesting -> master not granted last wins (round-robin), unless REQ-017 applies.
REQ-016 SHALL, with no requester, go to IDLE; a requester whose req was high at the edge enters GRANTx at the next cycle, so ack occurs one cycle after req first sampled from IDLE.
REQ-017 SHALL keep grant on master x after a transfer when mx_lock and mx_req are high and hold_cnt < MAX_HOLD-1; otherwise round-robin applies.
REQ-018 SHALL maintain 4-bit hold_cnt: increment on consecutive grant to same master while the other req is high, clear on grant switch, IDLE or other req low.
REQ-019 SHALL in GRANTx drive bus_address=mx_addr, bus_write_data=mx_wdata, bus_write_enable=mx_we, mx_ack=1, mx_rdata=bus_read_data, all combinational.
REQ-020 SHALL in IDLE drive bus_address=0, bus_write_data=0, bus_write_enable=0, both ack=0, both rdata=0.
REQ-021 SHALL drive non-granted master's ack=0 and rdata=0 at all times.
REQ-022 SHALL treat mx_req still high in the cycle after ack as a new request; master changes addr/we/wdata only in the cycle after ack.
REQ-023 SHALL never assert both acks or bus_write_enable outside GRANTx.
REQ-024 SHALL record last_grant on every GRANTx entry for round-robin.
REQ-025 SHALL ignore lock of the non-granted master and lock of a master whose req is low.

Reset
REQ-026 SHALL on rst high at a rising edge set state=IDLE, hold_cnt=0, last_grant=1 (m0 wins first tie).
REQ-027 SHALL force m0_ack, m1_ack, bus_write_enable to 0 combinationally while rst is high, aborting any in-flight transfer.
REQ-028 SHALL after rst deasserts accept requests at the first rising edge with rst low.

Verification
REQ-029 Reset, then m0_req=1, we=1, addr=0x1000, wdata=0xA5 -> next cycle GRANT0, bus_write_enable=1, bus_address=0x1000, m0_ack=1 for exactly one cycle.
REQ-030 Both req high continuously, no lock -> acks alternate m0,m1,m0,m1 starting with m0; bus_address tracks granted master each cycle.
REQ-031 MAX_HOLD=4, m0_lock=1, both req high -> m0 acked 4 consecutive cycles, then m1 acked; hold_cnt returns 0.
REQ-032 m1 read addr=0x2000, bus_read_data=0x3C -> m1_rdata=0x3C in ack cycle, m0_rdata=0, bus_write_enable=0.
REQ-033 rst asserted during GRANT1 with we=1 -> bus_write_enable=0 and m1_ack=0 that cycle; state IDLE next cycle; simultaneous req then grants m0 first.
REQ-034 m0 sole requester, m1_req rises during m0 lock burst -> m1 granted no later than MAX_HOLD transfers after its req is sampled.
